// File: rtl/jk_sync_counter.sv
// Modulo-MOD synchronous up/down counter built from per-bit edge-triggered JK cells.
// Define JK_CNT_OVF_STICKY_EN to make ovf a sticky wrap register (otherwise ovf is tied low).
module jk_sync_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);

    generate
        if (WIDTH < 2 || MOD < 2 || MOD > 2 ** WIDTH) begin : g_bad_params
            $error("jk_sync_counter: illegal WIDTH/MOD combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        DRV_HOLD,
        DRV_LOAD,
        DRV_UP,
        DRV_DOWN,
        DRV_UP_WRAP,
        DRV_DOWN_WRAP
    } drive_t;

    drive_t           drive;
    logic             at_top;
    logic             at_zero;
    logic [WIDTH-1:0] din_clamp;
    logic [WIDTH-1:0] ones_below;
    logic [WIDTH-1:0] zeros_below;

    // Prefix terms: bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        logic acc_one;
        logic acc_zero;
        acc_one     = 1'b1;
        acc_zero    = 1'b1;
        ones_below  = '0;
        zeros_below = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones_below[i]  = acc_one;
            zeros_below[i] = acc_zero;
            acc_one        = acc_one & q[i];
            acc_zero       = acc_zero & ~q[i];
        end
    end

    always_comb begin
        at_top    = (q == TOP);
        at_zero   = (q == '0);
        din_clamp = (din > TOP) ? TOP : din;

        drive = DRV_HOLD;
        if (load) begin
            drive = DRV_LOAD;
        end else if (en) begin
            if (up) begin
                drive = at_top ? DRV_UP_WRAP : DRV_UP;
            end else begin
                drive = at_zero ? DRV_DOWN_WRAP : DRV_DOWN;
            end
        end

        tc = en & ~load & ((up & at_top) | (~up & at_zero));
    end

    always_comb begin
        j_vec = '0;
        k_vec = '0;
        case (drive)
            DRV_LOAD: begin
                j_vec = din_clamp;
                k_vec = ~din_clamp;
            end
            DRV_UP: begin
                j_vec = ones_below;
                k_vec = ones_below;
            end
            DRV_DOWN: begin
                j_vec = zeros_below;
                k_vec = zeros_below;
            end
            DRV_UP_WRAP: begin
                j_vec = '0;
                k_vec = '1;
            end
            DRV_DOWN_WRAP: begin
                j_vec = TOP;
                k_vec = ~TOP;
            end
            default: begin
                j_vec = '0;
                k_vec = '0;
            end
        endcase
    end

    // Storage stage: each bit is an edge-triggered JK cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                q[i] <= (j_vec[i] & ~q[i]) | (~k_vec[i] & q[i]);
            end
        end
    end

`ifdef JK_CNT_OVF_STICKY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (load) begin
            ovf <= 1'b0;
        end else if (tc) begin
            ovf <= 1'b1;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_jk_sync_counter.sv
// Self-checking bench for jk_sync_counter (WIDTH=4, MOD=10) against an arithmetic reference model.
// Honours JK_CNT_OVF_STICKY_EN when predicting ovf.
module tb_jk_sync_counter;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] din;
    logic [W-1:0] q;
    logic [W-1:0] j_vec;
    logic [W-1:0] k_vec;
    logic         tc;
    logic         ovf;

    int total = 0;
    int bad   = 0;
    int m     = 0;   // reference count value
    int om    = 0;   // reference sticky flag

    jk_sync_counter #(.WIDTH(W), .MOD(MOD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .up    (up),
        .load  (load),
        .din   (din),
        .q     (q),
        .j_vec (j_vec),
        .k_vec (k_vec),
        .tc    (tc),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic l, input logic e, input logic u, input logic [W-1:0] d);
        int dc, nm, t;
        logic [W-1:0] ej, ek;
        logic etc;
        @(negedge clk);
        load = l; en = e; up = u; din = d;
        #1;
        dc  = (int'(d) > MOD - 1) ? MOD - 1 : int'(d);
        nm  = m;
        ej  = '0;
        ek  = '0;
        etc = 1'b0;
        if (l) begin
            nm = dc;
            ej = W'(dc);
            ek = ~W'(dc);
        end else if (e) begin
            if (u) begin
                if (m == MOD - 1) begin
                    nm = 0; ej = '0; ek = '1; etc = 1'b1;
                end else begin
                    nm = m + 1; t = m ^ nm; ej = W'(t); ek = W'(t);
                end
            end else begin
                if (m == 0) begin
                    nm = MOD - 1; ej = W'(MOD - 1); ek = ~W'(MOD - 1); etc = 1'b1;
                end else begin
                    nm = m - 1; t = m ^ nm; ej = W'(t); ek = W'(t);
                end
            end
        end
        chk("j_vec", 8'(j_vec), 8'(ej));
        chk("k_vec", 8'(k_vec), 8'(ek));
        chk("tc", 8'(tc), 8'(etc));
        @(posedge clk);
        #1;
        m = nm;
`ifdef JK_CNT_OVF_STICKY_EN
        if (l) om = 0;
        else if (etc) om = 1;
`endif
        chk("q", 8'(q), 8'(m));
        chk("ovf", 8'(ovf), 8'(om));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        load = 1'b0; en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m = 0; om = 0;
        chk("rst_q", 8'(q), 8'(0));
        chk("rst_ovf", 8'(ovf), 8'(0));
        chk("rst_tc", 8'(tc), 8'(0));
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; din = '0;
        #2;
        chk("reset_q", 8'(q), 8'(0));
        chk("reset_ovf", 8'(ovf), 8'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // up count across the MOD=10 wrap (covers j/k=1111 at q=7)
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, '0);
        // sticky flag survives further counts
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, '0);
        // load clears the flag on the same edge
        step(1'b1, 1'b1, 1'b1, 4'd2);

        // count to 5, then asynchronous reset between edges
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, '0);
        chk("at_five", 8'(q), 8'(5));
        pulse_reset();
        step(1'b0, 1'b0, 1'b1, '0);

        // down wrap from 0
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);

        // load priority over en, clamp of out-of-range din
        step(1'b1, 1'b1, 1'b1, 4'd12);
        step(1'b1, 1'b1, 1'b0, 4'd3);
        step(1'b1, 1'b1, 1'b1, 4'd15);
        step(1'b1, 1'b0, 1'b0, 4'd10);

        // hold at 6
        step(1'b1, 1'b0, 1'b1, 4'd6);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)));

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                pulse_reset();
            end else begin
                step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
